// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage core: forwarding mux selects,
// load-use / branch / HI-LO interlocks and the multi-cycle mult/div sequencer.
module hazard_ctrl #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic       id_branch,
    input  logic       id_hilo,
    input  logic [4:0] ex_rs,
    input  logic [4:0] ex_rt,
    input  logic [4:0] ex_rd,
    input  logic       ex_regwrite,
    input  logic       ex_memread,
    input  logic       ex_md_start,
    input  logic       ex_md_div,
    input  logic [4:0] mem_rd,
    input  logic       mem_regwrite,
    input  logic       mem_memread,
    input  logic [4:0] wb_rd,
    input  logic       wb_regwrite,
    output logic [2:0] IDforwardA,
    output logic [2:0] IDforwardB,
    output logic [2:0] forwardA,
    output logic [2:0] forwardB,
    output logic [2:0] MEMforwardA,
    output logic [2:0] MEMforwardB,
    output logic       stall_pc,
    output logic       stall_ifid,
    output logic       flush_idex,
    output logic       md_busy,
    output logic       md_done
);

    localparam logic [2:0] SEL_NONE  = 3'b000;
    localparam logic [2:0] SEL_IDFWD = 3'b001;
    localparam logic [2:0] SEL_EXMEM = 3'b010;
    localparam logic [2:0] SEL_MEMWB = 3'b001;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic {
        MD_IDLE,
        MD_RUN
    } md_state_e;

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic mem_alu_wr;
    logic wb_wr;
    logic ex_wr_nz;
    logic mem_ld_nz;
    logic fwd_mem_a, fwd_mem_b;
    logic fwd_wb_a, fwd_wb_b;
    logic id_src_ex, id_src_mem;
    logic load_use, branch_alu, branch_load, md_stall;
    logic hazard;

    // Register 0 is hardwired, so a zero destination never produces a match.
    always_comb begin
        mem_alu_wr = mem_regwrite & ~mem_memread & (mem_rd != 5'd0);
        wb_wr      = wb_regwrite & (wb_rd != 5'd0);
        ex_wr_nz   = ex_rd != 5'd0;
        mem_ld_nz  = mem_memread & (mem_rd != 5'd0);

        fwd_mem_a = mem_alu_wr & (mem_rd == ex_rs);
        fwd_mem_b = mem_alu_wr & (mem_rd == ex_rt);
        fwd_wb_a  = wb_wr & (wb_rd == ex_rs) & ~fwd_mem_a;
        fwd_wb_b  = wb_wr & (wb_rd == ex_rt) & ~fwd_mem_b;

        forwardA    = fwd_mem_a ? SEL_EXMEM : SEL_NONE;
        forwardB    = fwd_mem_b ? SEL_EXMEM : SEL_NONE;
        MEMforwardA = fwd_wb_a ? SEL_MEMWB : SEL_NONE;
        MEMforwardB = fwd_wb_b ? SEL_MEMWB : SEL_NONE;

        IDforwardA = SEL_NONE;
        IDforwardB = SEL_NONE;
        if (id_branch & id_use_rs & mem_alu_wr & (mem_rd == id_rs)) begin
            IDforwardA = SEL_IDFWD;
        end
        if (id_branch & id_use_rt & mem_alu_wr & (mem_rd == id_rt)) begin
            IDforwardB = SEL_IDFWD;
        end
    end

    always_comb begin
        id_src_ex = ex_wr_nz &
                    ((id_use_rs & (id_rs == ex_rd)) |
                     (id_use_rt & (id_rt == ex_rd)));
        id_src_mem = mem_ld_nz &
                     ((id_use_rs & (id_rs == mem_rd)) |
                      (id_use_rt & (id_rt == mem_rd)));

        load_use    = ex_memread & id_src_ex;
        branch_alu  = id_branch & ex_regwrite & id_src_ex;
        branch_load = id_branch & ((ex_memread & id_src_ex) | id_src_mem);
        md_stall    = id_hilo & ((state_q == MD_RUN) | ex_md_start);

        hazard     = load_use | branch_alu | branch_load | md_stall;
        stall_pc   = hazard;
        stall_ifid = hazard;
        flush_idex = hazard;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A start seen while running (or on the done cycle) is dropped.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            MD_IDLE: begin
                if (ex_md_start) begin
                    state_d = MD_RUN;
                    cnt_d   = ex_md_div ? DIV_LOAD : MULT_LOAD;
                end
            end
            MD_RUN: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = MD_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        md_busy = state_q == MD_RUN;
        md_done = (state_q == MD_RUN) & (cnt_q == '0);
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed pipeline scenarios followed by
// random traffic, checked against a cycle-level behavioural model.
module tb_hazard_ctrl;

    localparam int MULT_CYCLES = 4;
    localparam int DIV_CYCLES  = 32;

    typedef struct packed {
        logic       reset;
        logic [4:0] id_rs;
        logic [4:0] id_rt;
        logic       id_use_rs;
        logic       id_use_rt;
        logic       id_branch;
        logic       id_hilo;
        logic [4:0] ex_rs;
        logic [4:0] ex_rt;
        logic [4:0] ex_rd;
        logic       ex_regwrite;
        logic       ex_memread;
        logic       ex_md_start;
        logic       ex_md_div;
        logic [4:0] mem_rd;
        logic       mem_regwrite;
        logic       mem_memread;
        logic [4:0] wb_rd;
        logic       wb_regwrite;
    } stim_t;

    typedef struct packed {
        logic [17:0] fwd;
        logic        stall;
        logic        busy;
        logic        done;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [4:0] id_rs, id_rt;
    logic       id_use_rs, id_use_rt;
    logic       id_branch, id_hilo;
    logic [4:0] ex_rs, ex_rt, ex_rd;
    logic       ex_regwrite, ex_memread;
    logic       ex_md_start, ex_md_div;
    logic [4:0] mem_rd;
    logic       mem_regwrite, mem_memread;
    logic [4:0] wb_rd;
    logic       wb_regwrite;
    logic [2:0] IDforwardA, IDforwardB;
    logic [2:0] forwardA, forwardB;
    logic [2:0] MEMforwardA, MEMforwardB;
    logic       stall_pc, stall_ifid, flush_idex;
    logic       md_busy, md_done;

    int    total = 0;
    int    bad   = 0;
    int    md_left = 0;
    stim_t cur;
    exp_t  sb_q[$];

    hazard_ctrl #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (6)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_use_rs   (id_use_rs),
        .id_use_rt   (id_use_rt),
        .id_branch   (id_branch),
        .id_hilo     (id_hilo),
        .ex_rs       (ex_rs),
        .ex_rt       (ex_rt),
        .ex_rd       (ex_rd),
        .ex_regwrite (ex_regwrite),
        .ex_memread  (ex_memread),
        .ex_md_start (ex_md_start),
        .ex_md_div   (ex_md_div),
        .mem_rd      (mem_rd),
        .mem_regwrite(mem_regwrite),
        .mem_memread (mem_memread),
        .wb_rd       (wb_rd),
        .wb_regwrite (wb_regwrite),
        .IDforwardA  (IDforwardA),
        .IDforwardB  (IDforwardB),
        .forwardA    (forwardA),
        .forwardB    (forwardB),
        .MEMforwardA (MEMforwardA),
        .MEMforwardB (MEMforwardB),
        .stall_pc    (stall_pc),
        .stall_ifid  (stall_ifid),
        .flush_idex  (flush_idex),
        .md_busy     (md_busy),
        .md_done     (md_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Does register r get a value from a writer of rd? Register 0 never does.
    function automatic bit hit(logic we, logic [4:0] rd, logic [4:0] r);
        return we && rd != 5'd0 && rd == r;
    endfunction

    function automatic bit id_reads(stim_t s, logic we, logic [4:0] rd);
        return (s.id_use_rs && hit(we, rd, s.id_rs)) ||
               (s.id_use_rt && hit(we, rd, s.id_rt));
    endfunction

    function automatic exp_t model(stim_t s, int left);
        exp_t e;
        bit   alu_mem, ea, eb, ma, mb, ia, ib, st;
        alu_mem = s.mem_regwrite && !s.mem_memread;
        ea = hit(alu_mem, s.mem_rd, s.ex_rs);
        eb = hit(alu_mem, s.mem_rd, s.ex_rt);
        ma = !ea && hit(s.wb_regwrite, s.wb_rd, s.ex_rs);
        mb = !eb && hit(s.wb_regwrite, s.wb_rd, s.ex_rt);
        ia = s.id_branch && s.id_use_rs && hit(alu_mem, s.mem_rd, s.id_rs);
        ib = s.id_branch && s.id_use_rt && hit(alu_mem, s.mem_rd, s.id_rt);
        st = 0;
        if (s.ex_memread && id_reads(s, 1'b1, s.ex_rd)) st = 1;
        if (s.id_branch && s.ex_regwrite && id_reads(s, 1'b1, s.ex_rd)) st = 1;
        if (s.id_branch && id_reads(s, s.mem_memread, s.mem_rd)) st = 1;
        if (s.id_hilo && (left > 0 || s.ex_md_start)) st = 1;
        e.fwd = {ia ? 3'd1 : 3'd0, ib ? 3'd1 : 3'd0,
                 ea ? 3'd2 : 3'd0, eb ? 3'd2 : 3'd0,
                 ma ? 3'd1 : 3'd0, mb ? 3'd1 : 3'd0};
        e.stall = st;
        e.busy  = left > 0;
        e.done  = left == 1;
        return e;
    endfunction

    task automatic drive(input stim_t s);
        reset        = s.reset;
        id_rs        = s.id_rs;
        id_rt        = s.id_rt;
        id_use_rs    = s.id_use_rs;
        id_use_rt    = s.id_use_rt;
        id_branch    = s.id_branch;
        id_hilo      = s.id_hilo;
        ex_rs        = s.ex_rs;
        ex_rt        = s.ex_rt;
        ex_rd        = s.ex_rd;
        ex_regwrite  = s.ex_regwrite;
        ex_memread   = s.ex_memread;
        ex_md_start  = s.ex_md_start;
        ex_md_div    = s.ex_md_div;
        mem_rd       = s.mem_rd;
        mem_regwrite = s.mem_regwrite;
        mem_memread  = s.mem_memread;
        wb_rd        = s.wb_rd;
        wb_regwrite  = s.wb_regwrite;
    endtask

    // md_left counts the busy cycles still ahead, including the current one.
    task automatic apply(input stim_t s);
        @(posedge clk);
        if (cur.reset) md_left = 0;
        else if (md_left > 0) md_left--;
        else if (cur.ex_md_start)
            md_left = cur.ex_md_div ? DIV_CYCLES : MULT_CYCLES;
        #1;
        cur = s;
        drive(s);
        sb_q.push_back(model(s, md_left));
    endtask

    task automatic check(string name, logic [17:0] act, logic [17:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s @%0t: got %h want %h", name, $time, act, req);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("fwd", {IDforwardA, IDforwardB, forwardA, forwardB,
                              MEMforwardA, MEMforwardB}, e.fwd);
                check("stall", 18'({stall_pc, stall_ifid, flush_idex}),
                      18'({3{e.stall}}));
                check("md", 18'({md_busy, md_done}), 18'({e.busy, e.done}));
            end
        end
    end

    function automatic stim_t rand_stim();
        stim_t s;
        s = '0;
        s.reset        = $urandom_range(0, 63) == 0;
        s.id_rs        = 5'($urandom_range(0, 3));
        s.id_rt        = 5'($urandom_range(0, 3));
        s.id_branch    = $urandom_range(0, 3) == 0;
        s.id_use_rs    = s.id_branch | 1'($urandom);
        s.id_use_rt    = 1'($urandom);
        s.id_hilo      = $urandom_range(0, 3) == 0;
        s.ex_rs        = 5'($urandom_range(0, 3));
        s.ex_rt        = 5'($urandom_range(0, 3));
        s.ex_rd        = 5'($urandom_range(0, 3));
        s.ex_memread   = $urandom_range(0, 3) == 0;
        s.ex_regwrite  = s.ex_memread | 1'($urandom);
        s.ex_md_start  = $urandom_range(0, 9) == 0;
        s.ex_md_div    = $urandom_range(0, 3) == 0;
        s.mem_rd       = 5'($urandom_range(0, 3));
        s.mem_memread  = $urandom_range(0, 3) == 0;
        s.mem_regwrite = s.mem_memread | 1'($urandom);
        s.wb_rd        = 5'($urandom_range(0, 3));
        s.wb_regwrite  = 1'($urandom);
        return s;
    endfunction

    initial begin
        stim_t s;
        cur = '0;
        cur.reset = 1'b1;
        drive(cur);
        s = '0;
        s.reset = 1'b1;
        apply(s);
        apply('0);

        // ALU result in MEM feeds EX rs
        s = '0;
        s.mem_rd = 5'd3; s.mem_regwrite = 1; s.ex_rs = 5'd3;
        apply(s);
        // Same reg in MEM and WB: youngest wins
        s = '0;
        s.mem_rd = 5'd5; s.mem_regwrite = 1;
        s.wb_rd = 5'd5; s.wb_regwrite = 1; s.ex_rt = 5'd5;
        apply(s);

        // Load-use: one bubble, then WB forward
        s = '0;
        s.ex_memread = 1; s.ex_regwrite = 1; s.ex_rd = 5'd4;
        s.id_rs = 5'd4; s.id_use_rs = 1;
        apply(s);
        s = '0;
        s.mem_memread = 1; s.mem_regwrite = 1; s.mem_rd = 5'd4;
        s.id_rs = 5'd4; s.id_use_rs = 1;
        apply(s);
        s = '0;
        s.wb_regwrite = 1; s.wb_rd = 5'd4; s.ex_rs = 5'd4;
        apply(s);

        // Branch on a load result: two bubbles
        s = '0;
        s.id_branch = 1; s.id_use_rs = 1; s.id_rs = 5'd2;
        s.ex_memread = 1; s.ex_regwrite = 1; s.ex_rd = 5'd2;
        apply(s);
        s = '0;
        s.id_branch = 1; s.id_use_rs = 1; s.id_rs = 5'd2;
        s.mem_memread = 1; s.mem_regwrite = 1; s.mem_rd = 5'd2;
        apply(s);
        s = '0;
        s.id_branch = 1; s.id_use_rs = 1; s.id_rs = 5'd2;
        s.wb_regwrite = 1; s.wb_rd = 5'd2;
        apply(s);

        // Branch on an ALU result: bubble, then ID forward
        s = '0;
        s.id_branch = 1; s.id_use_rt = 1; s.id_rt = 5'd7;
        s.ex_regwrite = 1; s.ex_rd = 5'd7;
        apply(s);
        s = '0;
        s.id_branch = 1; s.id_use_rt = 1; s.id_rt = 5'd7;
        s.mem_regwrite = 1; s.mem_rd = 5'd7;
        apply(s);

        // div with mfhi waiting in ID
        s = '0;
        s.ex_md_start = 1; s.ex_md_div = 1; s.id_hilo = 1;
        apply(s);
        s = '0;
        s.id_hilo = 1;
        repeat (DIV_CYCLES + 2) apply(s);

        // mult runs to completion
        s = '0;
        s.ex_md_start = 1;
        apply(s);
        repeat (MULT_CYCLES + 1) apply('0);

        // reset part-way through a div
        s = '0;
        s.ex_md_start = 1; s.ex_md_div = 1;
        apply(s);
        repeat (9) apply('0);
        s = '0;
        s.reset = 1;
        apply(s);
        s = '0;
        s.id_hilo = 1;
        repeat (3) apply(s);

        repeat (1500) apply(rand_stim());
        apply('0);

        repeat (20) begin
            if (sb_q.size() > 0) @(negedge clk);
        end
        @(posedge clk);
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
